// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if : fetch, data and sram signals of the shared memory port
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        if_err;

    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_valid;
    logic [31:0] dm_rdata;
    logic        dm_err;

    logic        mem_cs;
    logic        mem_oe;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_gnt, if_valid, if_rdata, if_err,
        output dm_gnt, dm_valid, dm_rdata, dm_err,
        output mem_cs, mem_oe, mem_we, mem_addr, mem_wdata
    );

    // Requester / memory side
    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_gnt, if_valid, if_rdata, if_err,
        input  dm_gnt, dm_valid, dm_rdata, dm_err,
        input  mem_cs, mem_oe, mem_we, mem_addr, mem_wdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter : shares one sram port between fetch and data requesters
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter #(
    parameter int MEM_LAT    = 1,
    parameter int MAX_STREAK = 4
) (
    input  wire logic         clk,
    input  wire logic         reset,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [2:0] C_LAT        = 3'(MEM_LAT);
    localparam logic [3:0] C_MAX_STREAK = 4'(MAX_STREAK);

    state_t      state_q,    state_d;
    logic [3:0]  streak_q,   streak_d;
    logic [2:0]  lat_q,      lat_d;
    logic        owner_q,    owner_d;     // 1 = data requester
    logic [31:0] addr_q,     addr_d;
    logic        we_q,       we_d;
    logic [31:0] wdata_q,    wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic        if_err_q,   if_err_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;
    logic        dm_err_q,   dm_err_d;

    logic        w_can_grant;
    logic        w_dm_gnt;
    logic        w_if_gnt;
    logic [31:0] w_gnt_addr;
    logic        w_busy;
    logic        w_resp;

    always_comb begin
        w_can_grant = (state_q == S_IDLE) || (state_q == S_RESP);
        w_dm_gnt    = w_can_grant && bus.dm_req &&
                      !(bus.if_req && (streak_q == C_MAX_STREAK));
        w_if_gnt    = w_can_grant && bus.if_req && !w_dm_gnt;
        w_gnt_addr  = w_dm_gnt ? bus.dm_addr : bus.if_addr;

        state_d    = state_q;
        streak_d   = streak_q;
        lat_d      = lat_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        if_err_d   = if_err_q;
        dm_rdata_d = dm_rdata_q;
        dm_err_d   = dm_err_q;

        // Streak only counts data wins that kept a fetch waiting
        if (!bus.if_req || w_if_gnt) begin
            streak_d = 4'd0;
        end else if (w_dm_gnt && (streak_q != C_MAX_STREAK)) begin
            streak_d = streak_q + 4'd1;
        end

        case (state_q)
            S_BUSY: begin
                lat_d = lat_q - 3'd1;
                if (lat_q == 3'd1) begin
                    state_d = S_RESP;
                    if (owner_q) begin
                        dm_rdata_d = we_q ? 32'd0 : bus.mem_rdata;
                        dm_err_d   = 1'b0;
                    end else begin
                        if_rdata_d = bus.mem_rdata;
                        if_err_d   = 1'b0;
                    end
                end
            end
            S_IDLE, S_RESP: begin
                state_d = S_IDLE;
                if (w_dm_gnt || w_if_gnt) begin
                    owner_d = w_dm_gnt;
                    addr_d  = w_gnt_addr;
                    we_d    = w_dm_gnt && bus.dm_we;
                    wdata_d = w_dm_gnt ? bus.dm_wdata : 32'd0;
                    if (w_gnt_addr[1:0] != 2'b00) begin
                        // Misaligned: respond next cycle without touching memory
                        state_d = S_RESP;
                        if (w_dm_gnt) begin
                            dm_rdata_d = 32'd0;
                            dm_err_d   = 1'b1;
                        end else begin
                            if_rdata_d = 32'd0;
                            if_err_d   = 1'b1;
                        end
                    end else begin
                        state_d = S_BUSY;
                        lat_d   = C_LAT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            streak_q   <= 4'd0;
            lat_q      <= 3'd0;
            owner_q    <= 1'b0;
            addr_q     <= 32'd0;
            we_q       <= 1'b0;
            wdata_q    <= 32'd0;
            if_rdata_q <= 32'd0;
            if_err_q   <= 1'b0;
            dm_rdata_q <= 32'd0;
            dm_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            streak_q   <= streak_d;
            lat_q      <= lat_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            if_err_q   <= if_err_d;
            dm_rdata_q <= dm_rdata_d;
            dm_err_q   <= dm_err_d;
        end
    end

    assign w_busy = (state_q == S_BUSY);
    assign w_resp = (state_q == S_RESP);

    assign bus.if_gnt   = w_if_gnt;
    assign bus.dm_gnt   = w_dm_gnt;
    assign bus.if_valid = w_resp && !owner_q;
    assign bus.dm_valid = w_resp && owner_q;
    assign bus.if_rdata = if_rdata_q;
    assign bus.if_err   = if_err_q;
    assign bus.dm_rdata = dm_rdata_q;
    assign bus.dm_err   = dm_err_q;

    // The latency counter still holds its load value only in the first BUSY cycle
    assign bus.mem_cs    = w_busy;
    assign bus.mem_oe    = w_busy && !we_q;
    assign bus.mem_we    = w_busy && we_q && (lat_q == C_LAT);
    assign bus.mem_addr  = w_busy ? addr_q  : 32'd0;
    assign bus.mem_wdata = w_busy ? wdata_q : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter : directed bench for mem_port_arbiter (MEM_LAT 1 and 3)
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_port_arbiter_if a ();
    mem_port_arbiter_if b ();

    mem_port_arbiter #(.MEM_LAT(1), .MAX_STREAK(4)) u_lat1 (
        .clk   (clk),
        .reset (reset),
        .bus   (a)
    );

    mem_port_arbiter #(.MEM_LAT(3), .MAX_STREAK(4)) u_lat3 (
        .clk   (clk),
        .reset (reset),
        .bus   (b)
    );

    // sel chooses which instance receives requests and is observed
    logic        sel;
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;

    assign a.if_req   = if_req & ~sel;
    assign b.if_req   = if_req & sel;
    assign a.dm_req   = dm_req & ~sel;
    assign b.dm_req   = dm_req & sel;
    assign a.if_addr  = if_addr;
    assign b.if_addr  = if_addr;
    assign a.dm_we    = dm_we;
    assign b.dm_we    = dm_we;
    assign a.dm_addr  = dm_addr;
    assign b.dm_addr  = dm_addr;
    assign a.dm_wdata = dm_wdata;
    assign b.dm_wdata = dm_wdata;

    logic [31:0] mem0 [256];
    logic [31:0] mem1 [256];
    assign a.mem_rdata = mem0[a.mem_addr[9:2]];
    assign b.mem_rdata = mem1[b.mem_addr[9:2]];
    always @(posedge clk) if (a.mem_we) mem0[a.mem_addr[9:2]] <= a.mem_wdata;
    always @(posedge clk) if (b.mem_we) mem1[b.mem_addr[9:2]] <= b.mem_wdata;

    wire        o_if_gnt   = sel ? b.if_gnt   : a.if_gnt;
    wire        o_dm_gnt   = sel ? b.dm_gnt   : a.dm_gnt;
    wire        o_if_valid = sel ? b.if_valid : a.if_valid;
    wire        o_dm_valid = sel ? b.dm_valid : a.dm_valid;
    wire [31:0] o_if_rdata = sel ? b.if_rdata : a.if_rdata;
    wire [31:0] o_dm_rdata = sel ? b.dm_rdata : a.dm_rdata;
    wire        o_if_err   = sel ? b.if_err   : a.if_err;
    wire        o_dm_err   = sel ? b.dm_err   : a.dm_err;
    wire        o_cs       = sel ? b.mem_cs   : a.mem_cs;
    wire        o_oe       = sel ? b.mem_oe   : a.mem_oe;
    wire        o_we       = sel ? b.mem_we   : a.mem_we;
    wire [31:0] o_addr     = sel ? b.mem_addr : a.mem_addr;

    int n_run  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          sel;
        bit          is_dm;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          chk_rdata;
        bit          exp_err;
        int          exp_lat;
        int          exp_cs;
        int          exp_we;
    } vec_t;

    vec_t vecs [10];

    // One isolated request: wait for grant, then measure the response
    task automatic do_access(input int idx, input vec_t v);
        bit          granted;
        bit          got;
        int          lat;
        int          cs_n;
        int          oe_n;
        int          we_n;
        logic [31:0] rdata;
        logic        err;
        granted = 1'b0;
        got     = 1'b0;
        lat     = 0;
        cs_n    = 0;
        oe_n    = 0;
        we_n    = 0;
        rdata   = 32'd0;
        err     = 1'b0;
        sel     = v.sel;
        if (v.is_dm) begin
            dm_req   = 1'b1;
            dm_we    = v.we;
            dm_addr  = v.addr;
            dm_wdata = v.wdata;
        end else begin
            if_req  = 1'b1;
            if_addr = v.addr;
        end
        for (int i = 0; i < 20 && !granted; i++) begin
            @(negedge clk);
            if (v.is_dm ? o_dm_gnt : o_if_gnt) granted = 1'b1;
        end
        chk($sformatf("v%0d_grant", idx), {31'd0, granted}, 32'd1);
        @(posedge clk);
        #1;
        if_req = 1'b0;
        dm_req = 1'b0;
        if (granted) begin
            for (int k = 1; k <= 12 && !got; k++) begin
                @(negedge clk);
                cs_n += int'(o_cs);
                oe_n += int'(o_oe);
                we_n += int'(o_we);
                if (v.is_dm ? o_dm_valid : o_if_valid) begin
                    got   = 1'b1;
                    lat   = k;
                    rdata = v.is_dm ? o_dm_rdata : o_if_rdata;
                    err   = v.is_dm ? o_dm_err : o_if_err;
                end
            end
            chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
            chk($sformatf("v%0d_err", idx), {31'd0, err}, {31'd0, v.exp_err});
            chk($sformatf("v%0d_cs_cycles", idx), 32'(cs_n), 32'(v.exp_cs));
            chk($sformatf("v%0d_oe_cycles", idx), 32'(oe_n), v.we ? 32'd0 : 32'(v.exp_cs));
            chk($sformatf("v%0d_we_cycles", idx), 32'(we_n), 32'(v.exp_we));
            if (v.chk_rdata) chk($sformatf("v%0d_rdata", idx), rdata, v.exp_rdata);
            @(posedge clk);
            #1;
        end
    endtask

    logic [9:0]  exp_seq;
    logic [9:0]  got_seq;
    int          n_gnt;
    int          vc [3];
    int          nv;
    int          cyc;
    int          cs_win;
    bit          seen;
    bit          granted;

    initial begin
        //               sel is_dm we  addr          wdata         exp_rdata     chk  err lat cs we
        vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h00400020, 32'h0,        32'h8C220004, 1'b1, 1'b0, 2, 1, 0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 32'h00000010, 32'hDEADBEEF, 32'h00000000, 1'b1, 1'b0, 2, 1, 1};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h00000010, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0, 2, 1, 0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 32'h00400022, 32'h0,        32'h0,        1'b0, 1'b1, 1, 0, 0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 32'h00400020, 32'h0,        32'h8C220004, 1'b1, 1'b0, 2, 1, 0};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 32'h00000040, 32'h12345678, 32'h00000000, 1'b1, 1'b0, 4, 3, 1};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 32'h00000040, 32'h0,        32'h12345678, 1'b1, 1'b0, 4, 3, 0};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 32'h00000041, 32'hBAD0BAD0, 32'h0,        1'b0, 1'b1, 1, 0, 0};
        vecs[8] = '{1'b1, 1'b1, 1'b0, 32'h00000040, 32'h0,        32'h12345678, 1'b1, 1'b0, 4, 3, 0};
        vecs[9] = '{1'b1, 1'b0, 1'b0, 32'h00400020, 32'h0,        32'h8C220004, 1'b1, 1'b0, 4, 3, 0};

        for (int i = 0; i < 256; i++) begin
            mem0[i] = 32'd0;
            mem1[i] = 32'd0;
        end
        mem0[8] = 32'h8C220004;
        mem1[8] = 32'h8C220004;

        sel = 1'b0; if_req = 1'b0; if_addr = 32'd0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'd0; dm_wdata = 32'd0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ctl_lat1", {23'd0, a.if_gnt, a.dm_gnt, a.if_valid, a.dm_valid, a.if_err,
                             a.dm_err, a.mem_cs, a.mem_oe, a.mem_we}, 32'd0);
        chk("rst_ctl_lat3", {23'd0, b.if_gnt, b.dm_gnt, b.if_valid, b.dm_valid, b.if_err,
                             b.dm_err, b.mem_cs, b.mem_oe, b.mem_we}, 32'd0);
        chk("rst_data_lat1", a.if_rdata | a.dm_rdata | a.mem_addr | a.mem_wdata, 32'd0);
        chk("rst_data_lat3", b.if_rdata | b.dm_rdata | b.mem_addr | b.mem_wdata, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) do_access(i, vecs[i]);

        // Contention, MAX_STREAK = 4
        sel = 1'b0;
        exp_seq = 10'b0111101111;
        got_seq = 10'd0;
        n_gnt = 0;
        if_addr = 32'h00400020;
        dm_addr = 32'h00000010;
        dm_we   = 1'b0;
        if_req  = 1'b1;
        dm_req  = 1'b1;
        for (int c = 0; c < 100 && n_gnt < 10; c++) begin
            @(negedge clk);
            if (o_dm_gnt && o_if_gnt) chk("contend_one_hot", 32'd2, 32'd1);
            if (o_dm_gnt || o_if_gnt) begin
                got_seq[n_gnt] = o_dm_gnt;
                n_gnt++;
            end
        end
        @(posedge clk);
        #1;
        if_req = 1'b0;
        dm_req = 1'b0;
        chk("contend_count", 32'(n_gnt), 32'd10);
        for (int i = 0; i < 10; i++)
            chk($sformatf("contend_gnt%0d_is_dm", i), {31'd0, got_seq[i]}, {31'd0, exp_seq[i]});
        repeat (4) @(posedge clk);
        #1;

        // Back-to-back loads, MEM_LAT = 3
        sel = 1'b1;
        dm_addr = 32'h00000040;
        dm_we   = 1'b0;
        dm_req  = 1'b1;
        nv = 0;
        cyc = 0;
        cs_win = 0;
        for (int c = 0; c < 30 && nv < 3; c++) begin
            @(negedge clk);
            cyc++;
            if (o_dm_valid) begin
                vc[nv] = cyc;
                chk($sformatf("b2b_rdata%0d", nv), o_dm_rdata, 32'h12345678);
                nv++;
            end
            if (nv >= 1 && nv < 3) cs_win += int'(o_cs);
        end
        @(posedge clk);
        #1;
        dm_req = 1'b0;
        chk("b2b_valid_count", 32'(nv), 32'd3);
        if (nv == 3) begin
            chk("b2b_spacing0", 32'(vc[1] - vc[0]), 32'd4);
            chk("b2b_spacing1", 32'(vc[2] - vc[1]), 32'd4);
            chk("b2b_cs_cycles", 32'(cs_win), 32'd6);
        end
        repeat (6) @(posedge clk);
        #1;

        // Reset in the second BUSY cycle, MEM_LAT = 3
        sel = 1'b1;
        dm_addr = 32'h00000040;
        dm_we   = 1'b0;
        dm_req  = 1'b1;
        granted = 1'b0;
        for (int i = 0; i < 20 && !granted; i++) begin
            @(negedge clk);
            if (o_dm_gnt) granted = 1'b1;
        end
        chk("rstmid_grant", {31'd0, granted}, 32'd1);
        @(posedge clk);
        #1;
        dm_req = 1'b0;
        @(posedge clk);
        #1;
        chk("rstmid_cs_before", {31'd0, o_cs}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rstmid_ctl", {27'd0, o_cs, o_oe, o_we, o_dm_valid, o_if_valid}, 32'd0);
        chk("rstmid_addr", o_addr, 32'd0);
        chk("rstmid_rdata", o_dm_rdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (o_dm_valid) seen = 1'b1;
        end
        chk("rstmid_no_valid", {31'd0, seen}, 32'd0);
        @(posedge clk);
        #1;
        do_access(10, vecs[6]);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences and shares the single-ported `sram` between the instruction-fetch requester and the data-memory (load/store) requester. It arbitrates between the two, drives the memory control and address lines for a fixed number of cycles per access, and returns a one-cycle response to the winning requester. Data accesses have priority, and a streak limit guarantees fetch forward progress. Misaligned accesses are rejected without touching memory.

## Interface
Parameters:
- `MEM_LAT`, 1: memory busy cycles per access; legal range 1..7.
- `MAX_STREAK`, 4: consecutive data grants allowed while a fetch is pending; legal range 1..15.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `if_req`  in  1  fetch request; held until granted.
- `if_addr`  in  32  fetch byte address.
- `if_gnt`  out  1  fetch granted this cycle (combinational).
- `if_valid`  out  1  fetch response valid (one cycle).
- `if_rdata`  out  32  fetched instruction.
- `if_err`  out  1  misaligned fetch; qualified by `if_valid`.
- `dm_req`  in  1  data request; held until granted.
- `dm_we`  in  1  1 = store, 0 = load.
- `dm_addr`  in  32  data byte address.
- `dm_wdata`  in  32  store data.
- `dm_gnt`  out  1  data granted this cycle (combinational).
- `dm_valid`  out  1  data response valid (one cycle).
- `dm_rdata`  out  32  load data; 0 for stores.
- `dm_err`  out  1  misaligned data access; qualified by `dm_valid`.
- `mem_cs`, `mem_oe`, `mem_we`  out  1 each  sram controls.
- `mem_addr`  out  32  sram address.
- `mem_wdata`  out  32  sram write data.
- `mem_rdata`  in  32  sram read data.

## Operation
- FSM states: IDLE, BUSY, RESP.
- Grants may be issued only in IDLE or RESP.
- **Grant selection:**
  - `dm_gnt = dm_req & !(if_req & streak == MAX_STREAK)`.
  - `if_gnt = if_req & !dm_gnt`.
  - At most one grant is asserted per cycle.
- **Streak counter (4 bits):**
  - Increments on each `dm_gnt` while `if_req` is high.
  - Clears on `if_gnt`, and on any cycle with `if_req` low.
  - Saturates at `MAX_STREAK`.
- **Capture at grant edge:** owner (IF/DM), address, we (always 0 for IF), wdata.
- **Aligned grant** (`addr[1:0] == 0`): go to BUSY and load the latency counter with `MEM_LAT`.
- **Misaligned grant:** go straight to RESP with err = 1. No memory signal toggles.
- **BUSY:**
  - `mem_cs = 1`.
  - `mem_addr` / `mem_wdata` come from the captured registers.
  - `mem_oe = !we`.
  - `mem_we = we` only in the first BUSY cycle.
  - Counter decrements each cycle. On the edge where it reaches 0, `mem_rdata` is captured into the owner's rdata register (stores capture 0), and the FSM goes to RESP.
- **RESP:**
  - Owner's `*_valid = 1`, `*_err` as captured.
  - Next state is BUSY or RESP if a new grant is issued, otherwise IDLE.
- `*_rdata` and `*_err` hold their values until the owner's next response.
- **Outside BUSY:** `mem_cs`, `mem_oe`, `mem_we` = 0; `mem_addr` and `mem_wdata` = 0.

## Timing
- **Reset values:** all outputs 0, FSM = IDLE, streak = 0, latency counter = 0, captured registers = 0.
- **Aligned access latency:** request granted at edge N → BUSY for cycles N+1..N+`MEM_LAT` → valid in cycle N+`MEM_LAT`+1.
- **Misaligned access:** valid in cycle N+1.
- **Back-to-back throughput:** one aligned access per `MEM_LAT`+1 cycles, because the grant in RESP overlaps the response.
- **Simultaneous requests:** the data requester wins unless the streak is saturated.
- **Request dropped before grant:** no effect. Requesters must not drop before grant.
- **Reset mid-BUSY:** controls drop immediately (asynchronous). No valid is produced and the access is lost. A store whose `mem_we` cycle completed is not undone.
- `if_gnt` / `dm_gnt` depend combinationally on the requests and registered state only, not on `mem_rdata`.

## Test plan
- **Single fetch**, `MEM_LAT` = 1, `if_addr` = 0x00400020, memory word 0x8C220004 → `mem_cs` / `mem_oe` high for 1 cycle; `if_valid` two cycles after grant with `if_rdata` = 0x8C220004, `if_err` = 0.
- **Store then load** to 0x00000010, wdata 0xDEADBEEF:
  - Store: `mem_we` high exactly 1 cycle; `dm_valid` with `dm_rdata` = 0.
  - Load: `dm_rdata` = 0xDEADBEEF.
- **Contention:** both requests held continuously, `MAX_STREAK` = 4 → grant order DM,DM,DM,DM,IF,DM,DM,DM,DM,IF.
- **Misaligned fetch** at 0x00400022 → `if_valid` and `if_err` = 1 one cycle after grant; `mem_cs` never asserted.
- **Back-to-back loads**, `MEM_LAT` = 3 → `dm_valid` every 4 cycles; `mem_cs` high 3 of every 4 cycles.
- **Reset asserted in the second BUSY cycle**, `MEM_LAT` = 3 → all outputs 0 in the same cycle; no `dm_valid`; the next request after reset is served normally.
